execute_stage: RTL and testbench

Pipeline stage directly upstream of the writeback stage. It selects forwarded operands, runs the RV32I ALU plus the RV32M multiply/divide operations, and registers the results into the EX/M pipeline register. That register drives the `*M` inputs of the writeback stage. Divides run on an iterative radix-2 unit; while one is in progress, the stage asserts a stall and inserts bubbles.

---
 rtl/execute_stage_if.sv | 40 ++++
 rtl/execute_stage.sv | 191 +++++++++++++++++++
 tb/tb_execute_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Bundle between decode/hazard logic and the execute stage: E-side instruction
// fields in, EX/M pipeline register contents and the stall request out.
interface execute_stage_if #(
   parameter int DPW = 32,
   parameter int ADW = 5
);
   logic           regwriteE;
   logic           resultsrcE;
   logic           memwriteE;
   logic [4:0]     alu_ctrlE;
   logic           alusrcE;
   logic [DPW-1:0] Rd1E;
   logic [DPW-1:0] Rd2E;
   logic [DPW-1:0] ImmExtE;
   logic [ADW-1:0] RdE;
   logic [1:0]     forwardAE;
   logic [1:0]     forwardBE;
   logic [DPW-1:0] resultW;
   logic           flushE;

   logic           regwriteM;
   logic           resultsrcM;
   logic           memwriteM;
   logic [DPW-1:0] aluresultM;
   logic [DPW-1:0] Rd2M;
   logic [ADW-1:0] RdM;
   logic           busyE;

   modport master (
      output regwriteE, resultsrcE, memwriteE, alu_ctrlE, alusrcE,
             Rd1E, Rd2E, ImmExtE, RdE, forwardAE, forwardBE, resultW, flushE,
      input  regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM, busyE
   );

   modport slave (
      input  regwriteE, resultsrcE, memwriteE, alu_ctrlE, alusrcE,
             Rd1E, Rd2E, ImmExtE, RdE, forwardAE, forwardBE, resultW, flushE,
      output regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM, busyE
   );
endinterface

// File: rtl/execute_stage.sv
// RV32IM execute stage: operand forwarding, single-cycle ALU/multiplier,
// 32-step restoring divider, and the EX/M pipeline register.
module execute_stage #(
   parameter int DPW = 32,
   parameter int ADW = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   execute_stage_if.slave bus
);

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_SLL    = 5'd2;
   localparam logic [4:0] OP_SLT    = 5'd3;
   localparam logic [4:0] OP_SLTU   = 5'd4;
   localparam logic [4:0] OP_XOR    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_OR     = 5'd8;
   localparam logic [4:0] OP_AND    = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   localparam logic [DPW-1:0] MIN_INT = {1'b1, {(DPW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

   divState_t      state_q;
   logic [4:0]     count_q;
   logic [DPW-1:0] quo_q;
   logic [DPW-1:0] rem_q;
   logic [DPW-1:0] divisor_q;
   logic           negQ_q;
   logic           negR_q;
   logic           isRem_q;

   logic [DPW-1:0]   srcA, fwdB, srcB;
   logic [4:0]       shamt;
   logic [2*DPW-1:0] mulA, mulB, product;
   logic             isDivOp, isRemOp, signedDiv, divByZero, divOverflow, longDiv;
   logic [DPW-1:0]   absA, absB, shortDivResult, divResult, aluResult, resultE;
   logic [DPW:0]     shifted, trial;
   logic             busy;

   always_comb begin
      case (bus.forwardAE)
         2'b01:   srcA = bus.resultW;
         2'b10:   srcA = bus.aluresultM;
         default: srcA = bus.Rd1E;
      endcase
      case (bus.forwardBE)
         2'b01:   fwdB = bus.resultW;
         2'b10:   fwdB = bus.aluresultM;
         default: fwdB = bus.Rd2E;
      endcase
   end

   assign srcB  = bus.alusrcE ? bus.ImmExtE : fwdB;
   assign shamt = srcB[4:0];

   // One shared multiplier; operand extension picks signed/unsigned flavours.
   assign mulA    = {{DPW{srcA[DPW-1] & ((bus.alu_ctrlE == OP_MULH) | (bus.alu_ctrlE == OP_MULHSU))}}, srcA};
   assign mulB    = {{DPW{srcB[DPW-1] & (bus.alu_ctrlE == OP_MULH)}}, srcB};
   assign product = mulA * mulB;

   assign isDivOp     = (bus.alu_ctrlE == OP_DIV) | (bus.alu_ctrlE == OP_DIVU) |
                        (bus.alu_ctrlE == OP_REM) | (bus.alu_ctrlE == OP_REMU);
   assign isRemOp     = (bus.alu_ctrlE == OP_REM) | (bus.alu_ctrlE == OP_REMU);
   assign signedDiv   = (bus.alu_ctrlE == OP_DIV) | (bus.alu_ctrlE == OP_REM);
   assign divByZero   = (srcB == '0);
   assign divOverflow = signedDiv && (srcA == MIN_INT) && (srcB == '1);
   assign longDiv     = isDivOp && !divByZero && !divOverflow;

   assign absA = (signedDiv && srcA[DPW-1]) ? (-srcA) : srcA;
   assign absB = (signedDiv && srcB[DPW-1]) ? (-srcB) : srcB;

   always_comb begin
      shortDivResult = '0;
      if (divByZero) begin
         shortDivResult = isRemOp ? srcA : '1;
      end else if (divOverflow) begin
         shortDivResult = isRemOp ? '0 : MIN_INT;
      end
   end

   always_comb begin
      aluResult = '0;
      case (bus.alu_ctrlE)
         OP_ADD:    aluResult = srcA + srcB;
         OP_SUB:    aluResult = srcA - srcB;
         OP_SLL:    aluResult = srcA << shamt;
         OP_SLT:    aluResult = {{(DPW-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
         OP_SLTU:   aluResult = {{(DPW-1){1'b0}}, (srcA < srcB)};
         OP_XOR:    aluResult = srcA ^ srcB;
         OP_SRL:    aluResult = srcA >> shamt;
         OP_SRA:    aluResult = DPW'($signed(srcA) >>> shamt);
         OP_OR:     aluResult = srcA | srcB;
         OP_AND:    aluResult = srcA & srcB;
         OP_MUL:    aluResult = product[DPW-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:
                    aluResult = product[2*DPW-1:DPW];
         OP_DIV, OP_DIVU, OP_REM, OP_REMU:
                    aluResult = shortDivResult;
         default:   aluResult = '0;
      endcase
   end

   // Restoring step: shift the next dividend bit into the partial remainder.
   assign shifted = {rem_q, quo_q[DPW-1]};
   assign trial   = shifted - {1'b0, divisor_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= 5'd0;
         quo_q     <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         negQ_q    <= 1'b0;
         negR_q    <= 1'b0;
         isRem_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (longDiv && !bus.flushE) begin
                  state_q   <= BUSY;
                  count_q   <= 5'd0;
                  quo_q     <= absA;
                  rem_q     <= '0;
                  divisor_q <= absB;
                  negQ_q    <= signedDiv && (srcA[DPW-1] ^ srcB[DPW-1]);
                  negR_q    <= signedDiv && srcA[DPW-1];
                  isRem_q   <= isRemOp;
               end
            end
            BUSY: begin
               if (bus.flushE) begin
                  state_q <= IDLE;
               end else begin
                  quo_q   <= {quo_q[DPW-2:0], ~trial[DPW]};
                  rem_q   <= trial[DPW] ? shifted[DPW-1:0] : trial[DPW-1:0];
                  count_q <= count_q + 5'd1;
                  if (count_q == 5'd31) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign divResult = isRem_q ? (negR_q ? -rem_q : rem_q)
                              : (negQ_q ? -quo_q : quo_q);

   assign busy      = (state_q == BUSY) || ((state_q == IDLE) && longDiv);
   assign bus.busyE = busy;
   assign resultE   = (state_q == DONE) ? divResult : aluResult;

   // Bubbles clear only the control bits; data fields keep their last value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.regwriteM  <= 1'b0;
         bus.resultsrcM <= 1'b0;
         bus.memwriteM  <= 1'b0;
         bus.aluresultM <= '0;
         bus.Rd2M       <= '0;
         bus.RdM        <= '0;
      end else if (bus.flushE || busy) begin
         bus.regwriteM  <= 1'b0;
         bus.resultsrcM <= 1'b0;
         bus.memwriteM  <= 1'b0;
      end else begin
         bus.regwriteM  <= bus.regwriteE;
         bus.resultsrcM <= bus.resultsrcE;
         bus.memwriteM  <= bus.memwriteE;
         bus.aluresultM <= resultE;
         bus.Rd2M       <= fwdB;
         bus.RdM        <= bus.RdE;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU, forwarding, multiply,
// short and long divides, flush and reset during a divide.
module tb_execute_stage;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   execute_stage_if #(.DPW(32), .ADW(5)) bus ();

   execute_stage #(.DPW(32), .ADW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] ctrl, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
      bus.alu_ctrlE  = ctrl;
      bus.Rd1E       = a;
      bus.Rd2E       = b;
      bus.RdE        = rd;
      bus.ImmExtE    = 32'h0;
      bus.alusrcE    = 1'b0;
      bus.forwardAE  = 2'b00;
      bus.forwardBE  = 2'b00;
      bus.resultW    = 32'h0;
      bus.regwriteE  = 1'b1;
      bus.resultsrcE = 1'b0;
      bus.memwriteE  = 1'b0;
      bus.flushE     = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic runSingle(input string tag, input logic [4:0] ctrl,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expected);
      applyStimulus(ctrl, a, b, 5'd9);
      #1;
      checkOutput({tag, " busyE"}, {31'h0, bus.busyE}, 32'h0);
      stepCycle();
      checkOutput(tag, bus.aluresultM, expected);
   endtask

   task automatic runDivide(input string tag, input logic [4:0] ctrl,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expected);
      int cycles;
      applyStimulus(ctrl, a, b, 5'd10);
      #1;
      cycles = 0;
      while (bus.busyE === 1'b1 && cycles < 50) begin
         cycles++;
         stepCycle();
      end
      checkOutput({tag, " busy cycles"}, cycles, 32'd33);
      checkOutput({tag, " bubble regwriteM"}, {31'h0, bus.regwriteM}, 32'h0);
      stepCycle();
      checkOutput(tag, bus.aluresultM, expected);
      checkOutput({tag, " regwriteM"}, {31'h0, bus.regwriteM}, 32'h1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;

      $display("[TB] reset and basic ADD");
      applyStimulus(5'd0, 32'd5, 32'd0, 5'd3);
      bus.alusrcE = 1'b1;
      bus.ImmExtE = 32'd7;
      stepCycle();
      stepCycle();
      checkOutput("reset aluresultM", bus.aluresultM, 32'h0);
      checkOutput("reset regwriteM", {31'h0, bus.regwriteM}, 32'h0);
      checkOutput("reset RdM", {27'h0, bus.RdM}, 32'h0);
      checkOutput("reset busyE", {31'h0, bus.busyE}, 32'h0);
      rst_n = 1'b1;
      stepCycle();
      checkOutput("add result", bus.aluresultM, 32'd12);
      checkOutput("add regwriteM", {31'h0, bus.regwriteM}, 32'h1);
      checkOutput("add RdM", {27'h0, bus.RdM}, 32'd3);

      applyStimulus(5'd0, 32'd8, 32'h55, 5'd4);
      bus.alusrcE    = 1'b1;
      bus.ImmExtE    = 32'd8;
      bus.regwriteE  = 1'b0;
      bus.memwriteE  = 1'b1;
      bus.resultsrcE = 1'b1;
      stepCycle();
      checkOutput("store result", bus.aluresultM, 32'h10);
      checkOutput("store memwriteM", {31'h0, bus.memwriteM}, 32'h1);
      checkOutput("store resultsrcM", {31'h0, bus.resultsrcM}, 32'h1);
      checkOutput("store regwriteM", {31'h0, bus.regwriteM}, 32'h0);
      checkOutput("store Rd2M", bus.Rd2M, 32'h55);

      $display("[TB] forwarding");
      applyStimulus(5'd1, 32'hAAAA, 32'd99, 5'd4);
      bus.forwardAE = 2'b10;
      bus.forwardBE = 2'b01;
      bus.resultW   = 32'd3;
      stepCycle();
      checkOutput("fwd sub", bus.aluresultM, 32'h0D);
      checkOutput("fwd Rd2M", bus.Rd2M, 32'd3);
      applyStimulus(5'd0, 32'd1, 32'd2, 5'd4);
      bus.forwardAE = 2'b11;
      bus.forwardBE = 2'b11;
      bus.resultW   = 32'd100;
      stepCycle();
      checkOutput("fwd 11 as 00", bus.aluresultM, 32'd3);

      $display("[TB] ALU and multiply");
      runSingle("sra", 5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
      runSingle("slt", 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
      runSingle("sltu", 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
      runSingle("sll shamt", 5'd2, 32'd1, 32'h21, 32'd2);
      runSingle("undefined op", 5'd20, 32'd1, 32'd2, 32'd0);
      runSingle("mulh", 5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      runSingle("mulhu", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      runSingle("mul", 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
      runSingle("mulhsu", 5'd12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

      $display("[TB] long divides");
      runDivide("divu 100/7", 5'd15, 32'd100, 32'd7, 32'd14);
      runDivide("remu 100/7", 5'd17, 32'd100, 32'd7, 32'd2);
      runDivide("div -7/2", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      runDivide("rem -7/2", 5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

      $display("[TB] short-path divides");
      runSingle("divu by zero", 5'd15, 32'd5, 32'd0, 32'hFFFF_FFFF);
      runSingle("remu by zero", 5'd17, 32'd5, 32'd0, 32'd5);
      runSingle("div overflow", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

      $display("[TB] flush mid-divide");
      applyStimulus(5'd14, 32'hFFFF_FFF9, 32'd2, 5'd5);
      #1;
      checkOutput("flush start busyE", {31'h0, bus.busyE}, 32'h1);
      stepCycle();
      repeat (10) stepCycle();
      bus.flushE = 1'b1;
      stepCycle();
      applyStimulus(5'd0, 32'd1, 32'd1, 5'd6);
      #1;
      checkOutput("flush busyE low", {31'h0, bus.busyE}, 32'h0);
      checkOutput("flush bubble regwriteM", {31'h0, bus.regwriteM}, 32'h0);
      checkOutput("flush data held", bus.aluresultM, 32'h8000_0000);
      stepCycle();
      checkOutput("after flush add", bus.aluresultM, 32'd2);
      checkOutput("after flush regwriteM", {31'h0, bus.regwriteM}, 32'h1);

      $display("[TB] reset mid-divide");
      applyStimulus(5'd15, 32'd100, 32'd7, 5'd7);
      stepCycle();
      repeat (5) stepCycle();
      rst_n      = 1'b0;
      bus.flushE = 1'b1;
      stepCycle();
      checkOutput("rst mid aluresultM", bus.aluresultM, 32'h0);
      checkOutput("rst mid Rd2M", bus.Rd2M, 32'h0);
      checkOutput("rst mid RdM", {27'h0, bus.RdM}, 32'h0);
      checkOutput("rst mid regwriteM", {31'h0, bus.regwriteM}, 32'h0);
      applyStimulus(5'd0, 32'd2, 32'd3, 5'd8);
      #1;
      checkOutput("rst mid busyE", {31'h0, bus.busyE}, 32'h0);
      rst_n = 1'b1;
      stepCycle();
      checkOutput("after reset add", bus.aluresultM, 32'd5);
      checkOutput("after reset RdM", {27'h0, bus.RdM}, 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
